common_dffram_wport_arb: RTL



---
 rtl/common_dffram_wport_arb_pkg.sv | 13 +
 rtl/common_dffram_wport_arb_if.sv | 34 +++
 rtl/common_rr_arb2.sv | 32 +++
 rtl/common_dffram_wport_arb.sv | 94 +++++++++
 4 files changed

// File: rtl/common_dffram_wport_arb_pkg.sv
// rtl/common_dffram_wport_arb_pkg.sv - shared state encoding and requester count
package common_dffram_wport_arb_pkg;

   // Controller states: INIT runs the fill sweep, RUN arbitrates port A
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Number of write requesters sharing port A
   localparam int NUM_REQ = 2;

endpackage

// File: rtl/common_dffram_wport_arb_if.sv
// rtl/common_dffram_wport_arb_if.sv - requester, read-steer and RAM port-A bundle
interface common_dffram_wport_arb_if #(
   parameter int DATA_W = 1,
   parameter int ADDR_W = 1
);
   logic              flush;
   logic              init_busy;
   logic              w0_valid;
   logic              w0_ready;
   logic [ADDR_W-1:0] w0_addr;
   logic [DATA_W-1:0] w0_data;
   logic              w1_valid;
   logic              w1_ready;
   logic [ADDR_W-1:0] w1_addr;
   logic [DATA_W-1:0] w1_data;
   logic [ADDR_W-1:0] rd_addra;
   logic              rd_a_valid;
   logic [ADDR_W-1:0] ram_addra;
   logic              ram_ena;
   logic              ram_wea;
   logic [DATA_W-1:0] ram_dina;

   // Controller side
   modport slave (
      input  flush, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, rd_addra,
      output init_busy, w0_ready, w1_ready, rd_a_valid, ram_addra, ram_ena, ram_wea, ram_dina
   );

   // Requester / environment side
   modport master (
      output flush, w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, rd_addra,
      input  init_busy, w0_ready, w1_ready, rd_a_valid, ram_addra, ram_ena, ram_wea, ram_dina
   );
endinterface

// File: rtl/common_rr_arb2.sv
// rtl/common_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module common_rr_arb2
   import common_dffram_wport_arb_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt
);

   // ptr=0 prefers requester 0 on contention, ptr=1 prefers requester 1
   logic ptr;

   // A lone request wins outright; contention is settled by the pointer
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

   // Pointer moves to the other requester only when a grant is taken
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= 1'b0;
      end else if (advance && (gnt != '0)) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/common_dffram_wport_arb.sv
// rtl/common_dffram_wport_arb.sv - init sweep and write-port arbitration for the DFF RAM
module common_dffram_wport_arb
   import common_dffram_wport_arb_pkg::*;
#(
   parameter int                         RAM_DATA_WIDTH = 1,
   parameter int                         RAM_ADDR_WIDTH = 1,
   parameter logic [RAM_DATA_WIDTH-1:0]  FILL_VALUE     = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   common_dffram_wport_arb_if.slave bus
);

   state_t                    state;
   state_t                    state_nxt;
   logic [RAM_ADDR_WIDTH-1:0] cnt;
   logic [RAM_ADDR_WIDTH-1:0] cnt_nxt;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        gnt;
   logic                      run_open;

   // Writers may only compete in RUN when no flush is being taken
   assign run_open = (state == ST_RUN) && !bus.flush;
   assign req      = {bus.w1_valid, bus.w0_valid} & {NUM_REQ{run_open}};

   common_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (run_open),
      .gnt     (gnt)
   );

   // State and sweep counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state plus port-A steering: sweep write, granted write, or read
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      bus.init_busy  = 1'b0;
      bus.w0_ready   = 1'b0;
      bus.w1_ready   = 1'b0;
      bus.rd_a_valid = 1'b0;
      bus.ram_ena    = 1'b1;
      bus.ram_wea    = 1'b0;
      bus.ram_addra  = bus.rd_addra;
      bus.ram_dina   = FILL_VALUE;
      case (state)
         ST_INIT: begin
            bus.init_busy = 1'b1;
            bus.ram_wea   = 1'b1;
            bus.ram_addra = cnt;
            cnt_nxt       = cnt + 1'b1;
            if (cnt == '1) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               bus.rd_a_valid = 1'b1;
               state_nxt      = ST_INIT;
               cnt_nxt        = '0;
            end else if (gnt[0]) begin
               bus.w0_ready  = 1'b1;
               bus.ram_wea   = 1'b1;
               bus.ram_addra = bus.w0_addr;
               bus.ram_dina  = bus.w0_data;
            end else if (gnt[1]) begin
               bus.w1_ready  = 1'b1;
               bus.ram_wea   = 1'b1;
               bus.ram_addra = bus.w1_addr;
               bus.ram_dina  = bus.w1_data;
            end else begin
               bus.rd_a_valid = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
